// File: rtl/tnn_pkg.sv
// Shared definitions for the temporal neural network column: default sizes,
// neuron FSM states, derived-width helpers and the "no spike" encoding.
package tnn_pkg;

    localparam int DEF_RECEPTIVE_FIELD = 8;
    localparam int DEF_WBITS           = 3;
    localparam int DEF_GAMMA_CYCLES    = 16;
    localparam int DEF_THRESHOLD       = 8;

    typedef enum logic [1:0] {
        IDLE,
        INTEGRATE,
        FIRED
    } state_t;

    // Potential never exceeds every synapse saturated at its maximum weight.
    function automatic int calc_pbits(input int rf, input int wbits);
        return $clog2(rf * ((2 ** wbits) - 1) + 1);
    endfunction

    function automatic int calc_tbits(input int gamma_cycles);
        return $clog2(gamma_cycles + 1);
    endfunction

    // Truncated to the spike-time width at the point of use; stays all-ones.
    localparam logic [31:0] NO_SPIKE = '1;

endpackage

// File: rtl/rnl_synapse.sv
// One ramp-no-leak synapse: remembers whether its line has spiked this gamma,
// and contributes one unit per cycle until its ramp reaches the latched weight.
module rnl_synapse
    import tnn_pkg::*;
#(
    parameter int WBITS = DEF_WBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_spike,
    input  logic [WBITS-1:0] i_weight,
    output logic             o_c
);

    logic             r_active;
    logic [WBITS-1:0] r_ramp;
    logic [WBITS-1:0] r_weight;

    logic             w_active_eff;
    logic [WBITS-1:0] w_ramp_eff;
    logic [WBITS-1:0] w_weight_eff;
    logic             w_new;
    logic             w_c;

    // The gamma_start cycle is t=0 of a fresh gamma, so stale state is masked.
    assign w_active_eff = i_start ? 1'b0 : r_active;
    assign w_ramp_eff   = i_start ? '0 : r_ramp;
    assign w_weight_eff = i_start ? i_weight : r_weight;

    assign w_new = i_spike & ~w_active_eff;
    assign w_c   = i_en & (w_active_eff | w_new) & (w_ramp_eff < w_weight_eff);
    assign o_c   = w_c;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_ramp   <= '0;
            r_weight <= '0;
        end else if (i_en) begin
            r_active <= w_active_eff | w_new;
            r_ramp   <= w_ramp_eff + WBITS'(w_c);
            if (i_start) begin
                r_weight <= i_weight;
            end
        end
    end

endmodule

// File: rtl/rnl_temporal_neuron.sv
// SRM0-RNL temporal neuron: integrates ramp responses over one gamma cycle and
// fires once, reporting the cycle at which the body potential reached threshold.
module rnl_temporal_neuron
    import tnn_pkg::*;
#(
    parameter int RECEPTIVE_FIELD = DEF_RECEPTIVE_FIELD,
    parameter int WBITS           = DEF_WBITS,
    parameter int THRESHOLD       = DEF_THRESHOLD,
    parameter int GAMMA_CYCLES    = DEF_GAMMA_CYCLES,
    localparam int PBITS          = calc_pbits(RECEPTIVE_FIELD, WBITS),
    localparam int TBITS          = calc_tbits(GAMMA_CYCLES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             gamma_start,
    input  logic [RECEPTIVE_FIELD-1:0]       spikes_in,
    input  logic [RECEPTIVE_FIELD*WBITS-1:0] weights,
    output logic                             spike_out,
    output logic [TBITS-1:0]                 spike_time,
    output logic [PBITS-1:0]                 potential,
    output logic                             gamma_done,
    output logic                             busy
);

    localparam logic [PBITS-1:0] THR       = PBITS'(THRESHOLD);
    localparam logic [TBITS-1:0] T_LAST    = TBITS'(GAMMA_CYCLES - 1);
    localparam logic [TBITS-1:0] T_NOSPIKE = TBITS'(NO_SPIKE);

    state_t                     r_state;
    logic [TBITS-1:0]           r_t;
    logic [PBITS-1:0]           r_potential;
    logic                       r_spike_out;
    logic [TBITS-1:0]           r_spike_time;
    logic                       r_gamma_done;

    state_t                     w_state_eff;
    state_t                     w_state_next;
    logic                       w_busy;
    logic                       w_en;
    logic                       w_fire;
    logic                       w_done;
    logic [TBITS-1:0]           w_t;
    logic [RECEPTIVE_FIELD-1:0] w_c;
    logic [PBITS-1:0]           w_pop;
    logic [PBITS-1:0]           w_pot_base;
    logic [PBITS-1:0]           w_pot_next;

    assign w_busy      = (r_state != IDLE);
    assign w_en        = gamma_start | w_busy;
    assign w_t         = gamma_start ? '0 : r_t;
    assign w_state_eff = gamma_start ? INTEGRATE : r_state;

    for (genvar i = 0; i < RECEPTIVE_FIELD; i++) begin : g_syn
        rnl_synapse #(
            .WBITS(WBITS)
        ) u_syn (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_start (gamma_start),
            .i_en    (w_en),
            .i_spike (spikes_in[i]),
            .i_weight(weights[i*WBITS +: WBITS]),
            .o_c     (w_c[i])
        );
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < RECEPTIVE_FIELD; i++) begin
            w_pop = w_pop + PBITS'(w_c[i]);
        end
    end

    assign w_pot_base = gamma_start ? '0 : r_potential;
    assign w_pot_next = w_pot_base + w_pop;

    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        w_done       = 1'b0;
        case (w_state_eff)
            INTEGRATE: begin
                w_state_next = INTEGRATE;
                if (w_pot_next >= THR) begin
                    w_fire       = 1'b1;
                    w_state_next = FIRED;
                end
            end
            FIRED:   w_state_next = FIRED;
            default: w_state_next = IDLE;
        endcase
        // Last cycle of the gamma wins over staying in INTEGRATE/FIRED.
        if (w_en && (w_t == T_LAST)) begin
            w_state_next = IDLE;
            w_done       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_t          <= '0;
            r_potential  <= '0;
            r_spike_out  <= 1'b0;
            r_spike_time <= T_NOSPIKE;
            r_gamma_done <= 1'b0;
        end else begin
            r_spike_out  <= w_fire;
            r_gamma_done <= w_done;
            if (w_en) begin
                r_t         <= w_t + TBITS'(1);
                r_potential <= w_pot_next;
            end
            if (w_fire) begin
                r_spike_time <= w_t;
            end else if (gamma_start) begin
                r_spike_time <= T_NOSPIKE;
            end
        end
    end

    assign spike_out  = r_spike_out;
    assign spike_time = r_spike_time;
    assign potential  = r_potential;
    assign gamma_done = r_gamma_done;
    assign busy       = w_busy;

endmodule

// File: tb/tb_rnl_temporal_neuron.sv
// Directed bench for rnl_temporal_neuron with default parameters (8 inputs,
// 3-bit weights, threshold 8, 16-cycle gamma); expected values worked by hand.
module tb_rnl_temporal_neuron;

    logic        clk;
    logic        rst_n;
    logic        gamma_start;
    logic [7:0]  spikes_in;
    logic [23:0] weights;
    logic        spike_out;
    logic [4:0]  spike_time;
    logic [5:0]  potential;
    logic        gamma_done;
    logic        busy;

    int total;
    int bad;
    int n_spk;
    int n_done;

    rnl_temporal_neuron #(
        .RECEPTIVE_FIELD(8),
        .WBITS          (3),
        .THRESHOLD      (8),
        .GAMMA_CYCLES   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gamma_start(gamma_start),
        .spikes_in  (spikes_in),
        .weights    (weights),
        .spike_out  (spike_out),
        .spike_time (spike_time),
        .potential  (potential),
        .gamma_done (gamma_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit later; tally output pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        n_spk  += int'(spike_out);
        n_done += int'(gamma_done);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        n_spk       = 0;
        n_done      = 0;
        rst_n       = 1'b0;
        gamma_start = 1'b0;
        spikes_in   = '0;
        weights     = '0;
        tick();
        tick();
        check("rst_spike_out", spike_out, 0);
        check("rst_gamma_done", gamma_done, 0);
        check("rst_busy", busy, 0);
        check("rst_potential", potential, 0);
        check("rst_spike_time", spike_time, 31);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // All weights 7, all lines spike at t=0: fires immediately.
        n_spk = 0; n_done = 0;
        weights = 24'o77777777; gamma_start = 1'b1; spikes_in = 8'hFF;
        tick();
        gamma_start = 1'b0; spikes_in = 8'h00;
        check("t1_potential", potential, 8);
        check("t1_spike_out", spike_out, 1);
        check("t1_spike_time", spike_time, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_pulse_width", spike_out, 0);
        repeat (13) tick();
        check("t1_no_early_done", gamma_done, 0);
        tick();
        check("t1_done", gamma_done, 1);
        check("t1_done_busy", busy, 0);
        check("t1_final_pot", potential, 56);
        check("t1_spike_count", n_spk, 1);
        check("t1_spike_time_held", spike_time, 0);
        tick();
        check("t1_done_width", gamma_done, 0);

        // Only w[0]=7, every line spikes at t=2: zero weights add nothing.
        n_spk = 0; n_done = 0;
        weights = 24'o7; gamma_start = 1'b1;
        tick();
        gamma_start = 1'b0;
        tick();
        spikes_in = 8'hFF;
        tick();
        spikes_in = 8'h00;
        check("t2_pot_t3", potential, 1);
        repeat (5) tick();
        check("t2_pot_t8", potential, 6);
        tick();
        check("t2_pot_t9", potential, 7);
        repeat (6) tick();
        check("t2_pot_sat", potential, 7);
        check("t2_no_early_done", gamma_done, 0);
        tick();
        check("t2_done", gamma_done, 1);
        check("t2_spike_time", spike_time, 31);
        check("t2_spike_count", n_spk, 0);

        // w[0]=w[1]=5, line0 at t=0, line1 at t=3: crossing at t=5.
        n_spk = 0; n_done = 0;
        weights = 24'o55; gamma_start = 1'b1; spikes_in = 8'h01;
        tick();
        gamma_start = 1'b0; spikes_in = 8'h00;
        check("t3_pot_t1", potential, 1);
        tick();
        tick();
        check("t3_pot_t3", potential, 3);
        spikes_in = 8'h02;
        tick();
        spikes_in = 8'h00;
        check("t3_pot_t4", potential, 5);
        tick();
        check("t3_pot_t5", potential, 7);
        check("t3_no_spike_t5", spike_out, 0);
        tick();
        check("t3_pot_t6", potential, 8);
        check("t3_spike_out_t6", spike_out, 1);
        check("t3_spike_time", spike_time, 5);
        repeat (9) tick();
        tick();
        check("t3_done", gamma_done, 1);
        check("t3_final_pot", potential, 10);
        check("t3_spike_count", n_spk, 1);
        check("t3_spike_time_held", spike_time, 5);

        // w[0]=7 only; repeat pulses at t=1 and t=8 must not restart the ramp.
        n_spk = 0; n_done = 0;
        weights = 24'o7; gamma_start = 1'b1; spikes_in = 8'h01;
        tick();
        gamma_start = 1'b0;
        tick();
        spikes_in = 8'h00;
        check("t4_pot_t2", potential, 2);
        repeat (6) tick();
        spikes_in = 8'h01;
        tick();
        spikes_in = 8'h00;
        check("t4_pot_t9", potential, 7);
        repeat (6) tick();
        tick();
        check("t4_done", gamma_done, 1);
        check("t4_final_pot", potential, 7);
        check("t4_spike_count", n_spk, 0);

        // Crossing on the last cycle: spike_out and gamma_done together.
        n_spk = 0; n_done = 0;
        weights = 24'o17; gamma_start = 1'b1;
        tick();
        gamma_start = 1'b0;
        repeat (8) tick();
        spikes_in = 8'h01;
        tick();
        spikes_in = 8'h00;
        check("t5_pot_t10", potential, 1);
        repeat (5) tick();
        check("t5_pot_t15", potential, 6);
        spikes_in = 8'h02;
        tick();
        spikes_in = 8'h00;
        check("t5_spike_out", spike_out, 1);
        check("t5_done", gamma_done, 1);
        check("t5_spike_time", spike_time, 15);
        check("t5_pot", potential, 8);
        check("t5_busy", busy, 0);
        tick();
        check("t5_spike_width", spike_out, 0);

        // Third scenario aborted by gamma_start at t=4, restart with w[0]=2.
        weights = 24'o55; gamma_start = 1'b1; spikes_in = 8'h01;
        tick();
        gamma_start = 1'b0; spikes_in = 8'h00;
        tick();
        tick();
        spikes_in = 8'h02;
        tick();
        spikes_in = 8'h00;
        check("t6_pot_before_abort", potential, 5);
        n_spk = 0; n_done = 0;
        weights = 24'o2; gamma_start = 1'b1;
        tick();
        gamma_start = 1'b0;
        check("t6_abort_pot", potential, 0);
        check("t6_abort_spike_time", spike_time, 31);
        check("t6_abort_spike_out", spike_out, 0);
        check("t6_abort_done", gamma_done, 0);
        check("t6_abort_busy", busy, 1);
        spikes_in = 8'h01;
        tick();
        spikes_in = 8'h00;
        check("t6_new_pot_t2", potential, 1);
        tick();
        tick();
        check("t6_new_pot_t4", potential, 2);
        repeat (11) tick();
        check("t6_no_old_done", n_done, 0);
        tick();
        check("t6_new_done", gamma_done, 1);
        check("t6_new_spike_time", spike_time, 31);
        check("t6_spike_count", n_spk, 0);

        // Reset at t=3 of a firing gamma; spikes ignored afterwards in IDLE.
        weights = 24'o77777777; gamma_start = 1'b1; spikes_in = 8'hFF;
        tick();
        gamma_start = 1'b0; spikes_in = 8'h00;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t7_rst_spike_out", spike_out, 0);
        check("t7_rst_done", gamma_done, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_pot", potential, 0);
        check("t7_rst_spike_time", spike_time, 31);
        n_spk = 0; n_done = 0;
        spikes_in = 8'hFF;
        repeat (3) tick();
        check("t7_idle_pot", potential, 0);
        check("t7_idle_busy", busy, 0);
        check("t7_idle_spikes", n_spk, 0);
        gamma_start = 1'b1;
        tick();
        gamma_start = 1'b0; spikes_in = 8'h00;
        check("t7_restart_pot", potential, 8);
        check("t7_restart_spike", spike_out, 1);

        // Reset takes priority over a simultaneous gamma_start.
        rst_n = 1'b0; gamma_start = 1'b1; spikes_in = 8'hFF;
        tick();
        rst_n = 1'b1; gamma_start = 1'b0; spikes_in = 8'h00;
        check("t8_rst_over_start_busy", busy, 0);
        check("t8_rst_over_start_pot", potential, 0);
        tick();
        check("t8_stays_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rnl_temporal_neuron.md
Name: rnl_temporal_neuron

Overview:
Sequential successor to the combinational weighted-sum neuron. It integrates temporally coded input spikes over one gamma cycle using a ramp-no-leak (SRM0-RNL) response per synapse. It emits one output spike at the first cycle in which the body potential reaches threshold, and reports that spike time. It sits in a column between the input spike encoder and the WTA/STDP stages; receptive field, weight width, threshold and gamma length are all parameters.

Parameters:
RECEPTIVE_FIELD, 8, number of synaptic inputs
WBITS, 3, weight width; max weight 2^WBITS-1
THRESHOLD, 8, firing threshold; legal range 1..RECEPTIVE_FIELD*(2^WBITS-1)
GAMMA_CYCLES, 16, clock cycles per gamma cycle; must be >= 2
PBITS, $clog2(RECEPTIVE_FIELD*(2**WBITS-1)+1), potential width (derived)
TBITS, $clog2(GAMMA_CYCLES+1), spike-time width (derived); all-ones means "no spike"

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
gamma_start  in  1  one-cycle pulse; starts a gamma cycle with t=0 in this cycle; samples weights
spikes_in  in  RECEPTIVE_FIELD  spike lines; the first high per line per gamma starts that synapse's ramp
weights  in  RECEPTIVE_FIELD x WBITS  per-synapse weights; sampled only when gamma_start=1
spike_out  out  1  one-cycle pulse, at most once per gamma
spike_time  out  TBITS  t at which threshold was crossed; all-ones if no spike
potential  out  PBITS  registered body potential (debug/observability)
gamma_done  out  1  one-cycle pulse after the last cycle of a completed gamma
busy  out  1  high in INTEGRATE and FIRED

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; spike_out=0, gamma_done=0, busy=0, potential=0, spike_time=all-ones; all synapse active flags and ramps cleared. Reset overrides gamma_start and applies mid-gamma.
- States:
  - IDLE: spikes_in and weights ignored; gamma_start -> INTEGRATE.
  - INTEGRATE: counting, not yet fired.
  - FIRED: counting, already fired.
- Time counter t: 0 in the gamma_start cycle, then +1 per edge. The edge at t=GAMMA_CYCLES-1 returns the FSM to IDLE and sets gamma_done=1 for the next cycle.
- Synapse i in cycle t:
  - new_i = spikes_in[i] & ~active_i.
  - Contribution c_i = (active_i | new_i) & (ramp_i < w_i).
  - Effective w_i = weights[i] in the gamma_start cycle, latched value otherwise.
  - At the edge: active_i |= new_i, and ramp_i += c_i.
- Potential update: potential <= potential + popcount(c). This gives potential(t) = sum over i of min(t - t_i + 1, w_i) for t >= t_i. Width is PBITS, so no overflow is possible.
- Latency: spike in cycle t is visible in potential at t+1.
- Firing:
  - In INTEGRATE, if the next potential >= THRESHOLD at the edge ending cycle t: spike_out=1 and spike_time=t for the following cycle, state -> FIRED.
  - spike_time holds until the next gamma_start or reset.
- Repeat spikes on an already-active line are ignored.
- Weight 0 means the synapse never contributes.
- Spikes after firing still integrate; potential keeps updating, but no second spike_out.
- Crossing at t=GAMMA_CYCLES-1: spike_out and gamma_done assert in the same cycle.
- End of gamma with no crossing: spike_time=all-ones when gamma_done asserts.
- gamma_start while busy aborts the current gamma and restarts at t=0: potential, ramps and active flags cleared; weights resampled; spike_time=all-ones; no gamma_done for the aborted gamma.
- gamma_start in the gamma_start cycle itself is treated as the t=0 cycle: spikes in that cycle count at t=0.

Decomposition:
- Package tnn_pkg holds:
  - default RECEPTIVE_FIELD, WBITS, GAMMA_CYCLES;
  - state enum {IDLE, INTEGRATE, FIRED};
  - PBITS/TBITS derivation functions;
  - the NO_SPIKE constant (all-ones).
- Sub-module rnl_synapse (one per input via generate) holds active flag, latched weight and ramp counter, and outputs the c_i bit.
- Top level holds the FSM, t counter, popcount/adder, threshold compare and output registers.

Test Plan:
- Defaults, all weights=7, spikes_in=8'hFF at t=0 -> potential=8 at t=1, spike_out pulse at t=1, spike_time=0, one pulse only.
- w[0]=7, others 0, spike line0 at t=2 -> potential climbs 1..7 and saturates at 7; no spike_out; gamma_done after t=15; spike_time=31.
- w[0]=w[1]=5, line0 at t=0, line1 at t=3 -> potential 1,2,3,5,7,8; spike_time=5; spike_out in cycle t=6.
- w[0]=7 only, line0 pulsed at t=0 and t=1 -> second pulse ignored; max potential 7; no spike_out.
- Run the third scenario, re-assert gamma_start at t=4 -> potential=0, spike_time=31, no spike_out or gamma_done for the aborted gamma; the new gamma behaves from t=0.
- rst_n=0 for one cycle at t=3 -> next cycle all outputs at reset values and busy=0; later spikes ignored until gamma_start.
